skolem_shl_sge_checker: RTL and testbench



---
 rtl/skolem_shl_sge_checker.sv | 133 +++++++++++++
 tb/tb_skolem_shl_sge_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skolem_shl_sge_checker.sv
// Certification stage for a Skolem netlist of (s << x) >=s t: sweeps every {s,t}, checks the
// returned witness and classifies failures by exhaustive search. Option: SKC_STOP_ON_FAIL_EN.
module skolem_shl_sge_checker #(
   parameter int W      = 4,
   parameter int SK_LAT = 0,
   parameter int CNT_W  = 2*W+1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [2*W-1:0]   sk_vec,
   input  logic [W-1:0]     sk_x,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] vac_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             first_fail_vld,
   output logic [2*W-1:0]   first_fail_vec,
   output logic [W-1:0]     first_fail_x
);

   typedef enum logic [2:0] {IDLE, APPLY, CHECK, SEARCH, NEXT, DONE} state_t;

   state_t         state, nxt;
   logic [2*W-1:0] vec;
   logic [2:0]     wcnt;
   logic [W-1:0]   xs;
   logic [W-1:0]   wit;
   logic [W-1:0]   s_op, t_op;
   logic           wit_ok, cand_ok, last_xs, last_vec, lat_hit;

   function automatic logic holds(input logic [W-1:0] s, input logic [W-1:0] t,
                                  input logic [W-1:0] x);
      logic [W-1:0] sh;
      sh = (int'(x) >= W) ? '0 : (s << x);
      return $signed(sh) >= $signed(t);
   endfunction

   assign s_op     = vec[2*W-1:W];
   assign t_op     = vec[W-1:0];
   assign wit_ok   = holds(s_op, t_op, sk_x);
   assign cand_ok  = holds(s_op, t_op, xs);
   assign last_xs  = &xs;
   assign last_vec = &vec;
   assign lat_hit  = (wcnt == 3'(SK_LAT));

   assign sk_vec = vec;
   assign busy   = (state != IDLE) && (state != DONE);
   assign done   = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:   if (start) nxt = APPLY;
         APPLY:  if (lat_hit) nxt = CHECK;
         CHECK:  nxt = wit_ok ? NEXT : SEARCH;
         SEARCH: begin
            if (cand_ok) begin
`ifdef SKC_STOP_ON_FAIL_EN
               nxt = DONE;
`else
               nxt = NEXT;
`endif
            end else if (last_xs) begin
               nxt = NEXT;
            end
         end
         NEXT:    nxt = last_vec ? DONE : APPLY;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec            <= '0;
         wcnt           <= '0;
         xs             <= '0;
         wit            <= '0;
         pass_cnt       <= '0;
         vac_cnt        <= '0;
         fail_cnt       <= '0;
         first_fail_vld <= 1'b0;
         first_fail_vec <= '0;
         first_fail_x   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vec            <= '0;
                  wcnt           <= '0;
                  pass_cnt       <= '0;
                  vac_cnt        <= '0;
                  fail_cnt       <= '0;
                  first_fail_vld <= 1'b0;
                  first_fail_vec <= '0;
                  first_fail_x   <= '0;
               end
            end
            APPLY: wcnt <= lat_hit ? 3'd0 : wcnt + 3'd1;
            CHECK: begin
               wit <= sk_x;
               xs  <= '0;
               if (wit_ok) pass_cnt <= pass_cnt + CNT_W'(1);
            end
            SEARCH: begin
               // A hit anywhere means the netlist missed an existing witness.
               if (cand_ok) begin
                  fail_cnt <= fail_cnt + CNT_W'(1);
                  if (!first_fail_vld) begin
                     first_fail_vld <= 1'b1;
                     first_fail_vec <= vec;
                     first_fail_x   <= wit;
                  end
               end else if (last_xs) begin
                  vac_cnt <= vac_cnt + CNT_W'(1);
               end else begin
                  xs <= xs + W'(1);
               end
            end
            NEXT: if (!last_vec) vec <= vec + (2*W)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_skolem_shl_sge_checker.sv
// Scoreboard bench: two checker instances (SK_LAT 0 and 3) driven by behavioural netlist stubs.
module tb_skolem_shl_sge_checker;
   localparam int W     = 4;
   localparam int CNT_W = 2*W+1;
   localparam int NV    = 1 << (2*W);

   typedef struct {
      int pass; int vac; int fail; int ffvld; int ffvec; int ffx; int lastvec;
   } exp_t;

   logic clk, rst_n, start0, start3;
   logic [2*W-1:0] sk_vec0, sk_vec3, ffvec0, ffvec3;
   logic [W-1:0] sk_x0, sk_x3, ffx0, ffx3;
   logic busy0, busy3, done0, done3, ffvld0, ffvld3;
   logic [CNT_W-1:0] pass0, vac0, fail0, pass3, vac3, fail3;
   logic [W-1:0] p1, p2, p3;

   int   checks, errors;
   int   m0, m3;
   int   lut [NV];
   exp_t q0[$], q3[$];
   exp_t e0, e3;

   skolem_shl_sge_checker #(.W(W), .SK_LAT(0), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .sk_vec(sk_vec0), .sk_x(sk_x0),
      .busy(busy0), .done(done0), .pass_cnt(pass0), .vac_cnt(vac0), .fail_cnt(fail0),
      .first_fail_vld(ffvld0), .first_fail_vec(ffvec0), .first_fail_x(ffx0));

   skolem_shl_sge_checker #(.W(W), .SK_LAT(3), .CNT_W(CNT_W)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .sk_vec(sk_vec3), .sk_x(sk_x3),
      .busy(busy3), .done(done3), .pass_cnt(pass3), .vac_cnt(vac3), .fail_cnt(fail3),
      .first_fail_vld(ffvld3), .first_fail_vec(ffvec3), .first_fail_x(ffx3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int to_signed(input int v);
      return (v >= (1 << (W-1))) ? v - (1 << W) : v;
   endfunction

   function automatic bit m_holds(input int s, input int t, input int x);
      int sh;
      sh = (x >= W) ? 0 : ((s * (1 << x)) % (1 << W));
      return to_signed(sh) >= to_signed(t);
   endfunction

   function automatic bit m_exists(input int s, input int t);
      for (int x = 0; x < (1 << W); x++) if (m_holds(s, t, x)) return 1'b1;
      return 1'b0;
   endfunction

   // mode 0: smallest valid witness, mode 1: constant 0, mode 2: random table
   function automatic int stub_fn(input int mode, input int v);
      int s, t;
      s = v >> W;
      t = v % (1 << W);
      if (mode == 0) begin
         for (int x = 0; x < (1 << W); x++) if (m_holds(s, t, x)) return x;
         return 0;
      end
      if (mode == 1) return 0;
      return lut[v];
   endfunction

   always_comb sk_x0 = W'(stub_fn(m0, int'(sk_vec0)));

   always @(posedge clk) begin
      p1 <= W'(stub_fn(m3, int'(sk_vec3)));
      p2 <= p1;
      p3 <= p2;
   end
   assign sk_x3 = p3;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic build_exp(input int mode, output exp_t e);
      int w, s, t;
      e = '{default: 0};
      e.lastvec = NV - 1;
      for (int v = 0; v < NV; v++) begin
         s = v >> W;
         t = v % (1 << W);
         w = stub_fn(mode, v);
         if (m_holds(s, t, w)) e.pass++;
         else if (m_exists(s, t)) begin
            e.fail++;
            if (e.ffvld == 0) begin
               e.ffvld = 1; e.ffvec = v; e.ffx = w;
            end
`ifdef SKC_STOP_ON_FAIL_EN
            e.lastvec = v;
            break;
`endif
         end else e.vac++;
      end
   endtask

   task automatic cmp_done(input string tag, input exp_t e, input int p, input int v,
                           input int f, input int fv, input int fvec, input int fx,
                           input int vec);
      chk({tag, "_pass_cnt"}, p, e.pass);
      chk({tag, "_vac_cnt"}, v, e.vac);
      chk({tag, "_fail_cnt"}, f, e.fail);
      chk({tag, "_ff_vld"}, fv, e.ffvld);
      chk({tag, "_ff_vec"}, fvec, e.ffvec);
      chk({tag, "_ff_x"}, fx, e.ffx);
      chk({tag, "_sk_vec_at_done"}, vec, e.lastvec);
   endtask

   always @(negedge clk) begin
      if (done0) begin
         if (q0.size() == 0) chk("dut0_unexpected_done", 1, 0);
         else begin
            e0 = q0.pop_front();
            cmp_done("dut0", e0, int'(pass0), int'(vac0), int'(fail0), int'(ffvld0),
                     int'(ffvec0), int'(ffx0), int'(sk_vec0));
         end
      end
   end

   always @(negedge clk) begin
      if (done3) begin
         if (q3.size() == 0) chk("dut3_unexpected_done", 1, 0);
         else begin
            e3 = q3.pop_front();
            cmp_done("dut3", e3, int'(pass3), int'(vac3), int'(fail3), int'(ffvld3),
                     int'(ffvec3), int'(ffx3), int'(sk_vec3));
         end
      end
   end

   task automatic drive_start(input int which, input logic val);
      if (which == 0) start0 = val;
      else            start3 = val;
   endtask

   task automatic chk_zero(input string tag, input int which);
      if (which == 0) begin
         chk({tag, "_sk_vec"}, int'(sk_vec0), 0); chk({tag, "_busy"}, int'(busy0), 0);
         chk({tag, "_done"}, int'(done0), 0);     chk({tag, "_pass"}, int'(pass0), 0);
         chk({tag, "_vac"}, int'(vac0), 0);       chk({tag, "_fail"}, int'(fail0), 0);
         chk({tag, "_ffvld"}, int'(ffvld0), 0);   chk({tag, "_ffvec"}, int'(ffvec0), 0);
         chk({tag, "_ffx"}, int'(ffx0), 0);
      end else begin
         chk({tag, "_sk_vec"}, int'(sk_vec3), 0); chk({tag, "_busy"}, int'(busy3), 0);
         chk({tag, "_done"}, int'(done3), 0);     chk({tag, "_pass"}, int'(pass3), 0);
         chk({tag, "_vac"}, int'(vac3), 0);       chk({tag, "_fail"}, int'(fail3), 0);
         chk({tag, "_ffvld"}, int'(ffvld3), 0);   chk({tag, "_ffvec"}, int'(ffvec3), 0);
         chk({tag, "_ffx"}, int'(ffx3), 0);
      end
   endtask

   task automatic sweep(input int which, input int mode);
      exp_t e;
      int   lat, c17, dec, run, minrun, prev, vec;
      bit   seen, bsy, dn;
      lat = (which == 0) ? 0 : 3;
      if (which == 0) m0 = mode; else m3 = mode;
      build_exp(mode, e);
      if (which == 0) q0.push_back(e); else q3.push_back(e);
      c17 = 0; dec = 0; run = 0; minrun = 1 << 30; prev = 0; seen = 0;
      @(negedge clk) drive_start(which, 1'b1);
      @(negedge clk) drive_start(which, 1'b0);
      for (int cyc = 0; cyc < 30000; cyc++) begin
         @(negedge clk);
         // a second start mid-sweep must not restart the enumeration
         if (cyc == 10) drive_start(which, 1'b1);
         if (cyc == 11) drive_start(which, 1'b0);
         vec = (which == 0) ? int'(sk_vec0) : int'(sk_vec3);
         bsy = (which == 0) ? busy0 : busy3;
         dn  = (which == 0) ? done0 : done3;
         if (bsy) begin
            if (vec == 'h17) c17++;
            if (vec < prev) dec++;
            if (vec == prev) run++;
            else begin
               if (run > 0 && run < minrun) minrun = run;
               run = 1;
            end
            prev = vec;
         end
         if (dn) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         chk("sweep_timeout", 0, 1);
         return;
      end
      drive_start(which, 1'b1);
      @(negedge clk) drive_start(which, 1'b0);
      chk("start_in_done_ignored", (which == 0) ? int'(busy0) : int'(busy3), 0);
      chk("vec_monotonic", dec, 0);
      // 0x17 is vacuous: APPLY, CHECK, 16 SEARCH cycles, NEXT
      if (e.lastvec > 'h17) chk("hold_0x17_cycles", c17, (lat + 1) + 1 + (1 << W) + 1);
      if (which == 3 && e.lastvec > 0) chk("apply_hold_min4", int'(minrun >= lat + 1), 1);
   endtask

   initial begin
      int cnt;
      checks = 0; errors = 0;
      m0 = 0; m3 = 0;
      start0 = 1'b0; start3 = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < NV; i++) lut[i] = int'($urandom_range(0, (1 << W) - 1));
      repeat (3) @(negedge clk);
      chk_zero("reset0", 0);
      chk_zero("reset3", 3);
      rst_n = 1'b1;

      sweep(0, 0);
      sweep(0, 1);
      sweep(0, 2);
      sweep(3, 2);
      sweep(3, 0);
      sweep(3, 1);

      // abort mid-SEARCH on vector 0x17
      m0 = 0;
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      cnt = 0;
      while (!(busy0 && sk_vec0 == 8'h17) && cnt < 5000) begin
         @(negedge clk);
         cnt++;
      end
      chk("abort_reached_0x17", int'(cnt < 5000), 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_zero("abort_reset", 0);
      @(negedge clk);
      chk_zero("abort_hold", 0);
      rst_n = 1'b1;
      sweep(0, 0);
      for (int i = 0; i < NV; i++) lut[i] = int'($urandom_range(0, (1 << W) - 1));
      sweep(0, 2);

      repeat (5) @(negedge clk);
      chk("queue0_drained", q0.size(), 0);
      chk("queue3_drained", q3.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
